// File: rtl/vote_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vote_session_ctrl
//  Function : Timed voting session with a round-robin arbiter over two
//             booths feeding a saturating weighted tally
//             (normal x1, VIP x4, VVIP x16).
//  Revision : 1.0 - initial release
// ============================================================================
module vote_session_ctrl #(
    parameter int WINDOW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  threshold,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] np0,
    input  logic [31:0] np1,
    input  logic [7:0]  vip0,
    input  logic [7:0]  vip1,
    input  logic        vvip0,
    input  logic        vvip1,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  total
);

    localparam logic [7:0] c_window_len = 8'(WINDOW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  r_thresh;
    logic [7:0]  r_total;
    logic        r_pass;
    logic        r_prio;        // booth that wins when both request

    logic [1:0]  w_grant;
    logic        w_accept;
    logic        w_close;
    logic [31:0] w_np_sel;
    logic [7:0]  w_vip_sel;
    logic        w_vvip_sel;
    logic [5:0]  w_np_cnt;
    logic [3:0]  w_vip_cnt;
    logic [6:0]  w_weight;
    logic [8:0]  w_sum;
    logic [7:0]  w_total_acc;
    logic [7:0]  w_total_final;

    // Next state and grant; abort suppresses any grant in its cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 2'b00;
        w_close     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_OPEN;
                end
            end
            S_OPEN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (req0 && (!req1 || !r_prio)) begin
                        w_grant = 2'b01;
                    end else if (req1) begin
                        w_grant = 2'b10;
                    end
                    if (r_cnt <= 8'd1) begin
                        w_close     = 1'b1;
                        w_state_nxt = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept   = |w_grant;
    assign w_np_sel   = w_grant[1] ? np1   : np0;
    assign w_vip_sel  = w_grant[1] ? vip1  : vip0;
    assign w_vvip_sel = w_grant[1] ? vvip1 : vvip0;

    always_comb begin
        w_np_cnt  = 6'd0;
        w_vip_cnt = 4'd0;
        for (int i = 0; i < 32; i++) begin
            w_np_cnt = w_np_cnt + 6'(w_np_sel[i]);
        end
        for (int j = 0; j < 8; j++) begin
            w_vip_cnt = w_vip_cnt + 4'(w_vip_sel[j]);
        end
    end

    assign w_weight      = {1'b0, w_np_cnt}
                         + {1'b0, w_vip_cnt, 2'b00}
                         + {2'b00, w_vvip_sel, 4'b0000};
    assign w_sum         = {1'b0, r_total} + {2'b00, w_weight};
    assign w_total_acc   = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_total_final = w_accept ? w_total_acc : r_total;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 8'd0;
            r_thresh <= 8'd0;
            r_total  <= 8'd0;
            r_pass   <= 1'b0;
            r_prio   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= c_window_len;
                        r_thresh <= threshold;
                        r_total  <= 8'd0;
                        r_pass   <= 1'b0;
                    end
                end
                S_OPEN: begin
                    if (abort) begin
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                        if (w_accept) begin
                            r_total <= w_total_acc;
                            r_prio  <= w_grant[0];
                        end
                        // The last ballot lands on the closing edge, so judge the updated total.
                        if (w_close) begin
                            r_pass <= (w_total_final >= r_thresh);
                        end
                    end
                end
                default: begin
                    r_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign grant = w_grant;
    assign busy  = (r_state == S_OPEN);
    assign done  = (r_state == S_REPORT);
    assign pass  = r_pass;
    assign total = r_total;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vote_session_ctrl
//  Function : Directed self-checking bench; drives a WINDOW=16 and a WINDOW=1
//             instance from shared stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vote_session_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [7:0]  threshold;
    logic        req0, req1;
    logic [31:0] np0, np1;
    logic [7:0]  vip0, vip1;
    logic        vvip0, vvip1;

    logic [1:0]  grant16, grant1;
    logic        busy16, busy1, done16, done1, pass16, pass1;
    logic [7:0]  total16, total1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vote_session_ctrl #(.WINDOW(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .threshold(threshold),
        .req0(req0), .req1(req1), .np0(np0), .np1(np1), .vip0(vip0), .vip1(vip1),
        .vvip0(vvip0), .vvip1(vvip1), .grant(grant16), .busy(busy16), .done(done16),
        .pass(pass16), .total(total16)
    );

    vote_session_ctrl #(.WINDOW(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .threshold(threshold),
        .req0(req0), .req1(req1), .np0(np0), .np1(np1), .vip0(vip0), .vip1(vip1),
        .vvip0(vvip0), .vvip1(vvip1), .grant(grant1), .busy(busy1), .done(done1),
        .pass(pass1), .total(total1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (total16 !== 8'd0) $display("FAIL reset_total: got %0d expected 0", total16); else n_pass++;
        n_checks++; if (pass16 !== 1'b0) $display("FAIL reset_pass: got %b expected 0", pass16); else n_pass++;
        n_checks++; if (busy16 !== 1'b0 || done16 !== 1'b0) $display("FAIL reset_busy_done: got %b%b expected 00", busy16, done16); else n_pass++;
        reset = 1'b0;
        req0  = 1'b1;
        np0   = 32'h1;
        #1;
        n_checks++; if (grant16 !== 2'b00 || grant1 !== 2'b00) $display("FAIL idle_grant: got %b/%b expected 00/00", grant16, grant1); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done16 || done1) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL idle_done: got %0d pulses expected 0", pulses); else n_pass++;
        n_checks++; if (total16 !== 8'd0 || busy16 !== 1'b0) $display("FAIL idle_state: got total=%0d busy=%b expected 0/0", total16, busy16); else n_pass++;
        req0 = 1'b0;
        np0  = 32'h0;
    endtask

    task automatic test_single();
        threshold = 8'd80;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy16 !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy16); else n_pass++;
        req0 = 1'b1; np0 = 32'h86F7; vip0 = 8'h0F; vvip0 = 1'b0;
        #1;
        n_checks++; if (grant16 !== 2'b01) $display("FAIL single_grant1: got %b expected 01", grant16); else n_pass++;
        tick();
        n_checks++; if (total16 !== 8'd26) $display("FAIL single_total1: got %0d expected 26", total16); else n_pass++;
        req0 = 1'b0;
        tick();
        req0 = 1'b1; np0 = 32'hFFFF; vip0 = 8'hFF; vvip0 = 1'b1;
        #1;
        n_checks++; if (grant16 !== 2'b01) $display("FAIL single_grant2: got %b expected 01", grant16); else n_pass++;
        tick();
        n_checks++; if (total16 !== 8'd90) $display("FAIL single_total2: got %0d expected 90", total16); else n_pass++;
        req0 = 1'b0; np0 = 32'h0; vip0 = 8'h0; vvip0 = 1'b0;
        repeat (12) tick();
        n_checks++; if (done16 !== 1'b0 || busy16 !== 1'b1) $display("FAIL single_last_open: got done=%b busy=%b expected 0/1", done16, busy16); else n_pass++;
        tick();
        n_checks++; if (done16 !== 1'b1 || busy16 !== 1'b0) $display("FAIL single_report: got done=%b busy=%b expected 1/0", done16, busy16); else n_pass++;
        n_checks++; if (pass16 !== 1'b1 || total16 !== 8'd90) $display("FAIL single_result: got pass=%b total=%0d expected 1/90", pass16, total16); else n_pass++;
        tick();
        n_checks++; if (done16 !== 1'b0 || pass16 !== 1'b1 || total16 !== 8'd90) $display("FAIL single_hold: got done=%b pass=%b total=%0d expected 0/1/90", done16, pass16, total16); else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        int k;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        threshold = 8'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        req0 = 1'b1; req1 = 1'b1; np0 = 32'h1; np1 = 32'h1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (grant16 !== exp_g[i]) $display("FAIL contention_grant%0d: got %b expected %b", i, grant16, exp_g[i]); else n_pass++;
            tick();
        end
        n_checks++; if (total16 !== 8'd4) $display("FAIL contention_total: got %0d expected 4", total16); else n_pass++;
        req0 = 1'b0; req1 = 1'b0;
        k = 0;
        while (!done16 && k < 40) begin tick(); k++; end
        n_checks++; if (done16 !== 1'b1) $display("FAIL contention_done: got %b expected 1", done16); else n_pass++;
        n_checks++; if (pass16 !== 1'b0 || total16 !== 8'd4) $display("FAIL contention_result: got pass=%b total=%0d expected 0/4", pass16, total16); else n_pass++;
        tick();
        np0 = 32'h0; np1 = 32'h0;
    endtask

    task automatic test_saturation();
        logic [7:0] exp_t [4];
        int k;
        exp_t = '{8'd80, 8'd160, 8'd240, 8'd255};
        threshold = 8'd255;
        start     = 1'b1;
        tick();
        start = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        np0 = 32'hFFFF_FFFF; np1 = 32'hFFFF_FFFF;
        vip0 = 8'hFF; vip1 = 8'hFF; vvip0 = 1'b1; vvip1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (total16 !== exp_t[i]) $display("FAIL sat_total%0d: got %0d expected %0d", i, total16, exp_t[i]); else n_pass++;
        end
        req0 = 1'b0; req1 = 1'b0;
        np0 = 32'h0; np1 = 32'h0; vip0 = 8'h0; vip1 = 8'h0; vvip0 = 1'b0; vvip1 = 1'b0;
        k = 0;
        while (!done16 && k < 40) begin tick(); k++; end
        n_checks++; if (done16 !== 1'b1 || pass16 !== 1'b1 || total16 !== 8'd255) $display("FAIL sat_result: got done=%b pass=%b total=%0d expected 1/1/255", done16, pass16, total16); else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        int pulses;
        threshold = 8'd10;
        start     = 1'b1;
        tick();
        start = 1'b0;
        np0 = 32'h1; np1 = 32'h1;
        for (int i = 0; i < 4; i++) begin
            req0 = (i % 2 == 0);
            req1 = (i % 2 != 0);
            tick();
        end
        n_checks++; if (total16 !== 8'd4) $display("FAIL abort_partial: got %0d expected 4", total16); else n_pass++;
        req0 = 1'b1; req1 = 1'b0; abort = 1'b1;
        #1;
        n_checks++; if (grant16 !== 2'b00) $display("FAIL abort_grant: got %b expected 00", grant16); else n_pass++;
        tick();
        abort = 1'b0; req0 = 1'b0;
        n_checks++; if (busy16 !== 1'b0 || done16 !== 1'b0) $display("FAIL abort_idle: got busy=%b done=%b expected 0/0", busy16, done16); else n_pass++;
        n_checks++; if (total16 !== 8'd4 || pass16 !== 1'b0) $display("FAIL abort_hold: got total=%0d pass=%b expected 4/0", total16, pass16); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done16) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); else n_pass++;
        threshold = 8'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (total16 !== 8'd0 || busy16 !== 1'b1) $display("FAIL restart_clear: got total=%0d busy=%b expected 0/1", total16, busy16); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        np0 = 32'h0; np1 = 32'h0;
    endtask

    task automatic test_window1();
        threshold = 8'd1;
        start     = 1'b1;
        tick();
        req0 = 1'b1; np0 = 32'h3;
        #1;
        n_checks++; if (grant1 !== 2'b01 || busy1 !== 1'b1) $display("FAIL w1_grant: got grant=%b busy=%b expected 01/1", grant1, busy1); else n_pass++;
        tick();
        start = 1'b0;
        n_checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) $display("FAIL w1_report: got done=%b busy=%b expected 1/0", done1, busy1); else n_pass++;
        n_checks++; if (total1 !== 8'd2 || pass1 !== 1'b1) $display("FAIL w1_result: got total=%0d pass=%b expected 2/1", total1, pass1); else n_pass++;
        n_checks++; if (total16 !== 8'd2 || busy16 !== 1'b1) $display("FAIL ignored_start: got total=%0d busy=%b expected 2/1", total16, busy16); else n_pass++;
        n_checks++; if (grant1 !== 2'b00) $display("FAIL w1_report_grant: got %b expected 00", grant1); else n_pass++;
        req0 = 1'b0; np0 = 32'h0;
        tick();
        n_checks++; if (done1 !== 1'b0 || total1 !== 8'd2) $display("FAIL w1_after: got done=%b total=%0d expected 0/2", done1, total1); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; threshold = 8'd0;
        req0 = 1'b0; req1 = 1'b0; np0 = 32'h0; np1 = 32'h0;
        vip0 = 8'h0; vip1 = 8'h0; vvip0 = 1'b0; vvip1 = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_saturation();
        test_abort();
        test_window1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
